// File: rtl/com_pkg.sv
// Shared types for the com link sequencer: packet type codes, FSM states, result codes.
package com_pkg;

  localparam logic [3:0] BAG_INIT   = 4'b0000;
  localparam logic [3:0] BAG_ACK    = 4'b0001;
  localparam logic [3:0] BAG_NAK    = 4'b0010;
  localparam logic [3:0] BAG_STL    = 4'b0011;
  localparam logic [3:0] BAG_DIDX   = 4'b0101;
  localparam logic [3:0] BAG_DPARAM = 4'b0110;
  localparam logic [3:0] BAG_DDIDX  = 4'b0111;
  localparam logic [3:0] BAG_DLINK  = 4'b1000;
  localparam logic [3:0] BAG_DTYPE  = 4'b1001;
  localparam logic [3:0] BAG_DTEMP  = 4'b1010;
  localparam logic [3:0] BAG_DATA0  = 4'b1101;
  localparam logic [3:0] BAG_DATA1  = 4'b1110;
  localparam logic [3:0] BAG_ERROR  = 4'b1111;

  typedef enum logic [3:0] {
    MAIN_IDLE, MAIN_WAIT,
    SEND_PREP, SEND_DATA, RANS_WAIT, RANS_TAKE, RANS_DONE, SEND_DONE,
    READ_PREP, READ_DATA, WANS_PREP, WANS_DONE, READ_DONE
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_ACK  = 2'd1,
    RES_NAK  = 2'd2,
    RES_TMO  = 2'd3
  } send_result_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/com_arq_if.sv
// Handshake bundle between the sequencer (slave) and its upper layer, framer and parser (master).
interface com_arq_if #(parameter int ADDR_W = 12);
  logic              fs_send, fd_send;
  logic [3:0]        send_btype;
  logic [ADDR_W-1:0] send_dlen, send_ram_init;
  logic [1:0]        send_result;
  logic [7:0]        send_tries;
  logic              fs_read, fd_read;
  logic [3:0]        read_btype;
  logic              fs_tx, fd_tx;
  logic [3:0]        tx_btype;
  logic [ADDR_W-1:0] tx_ram_init, tx_ram_rlen;
  logic              fs_rx, fd_rx;
  logic [3:0]        rx_btype;
`ifdef COM_ARQ_STAT_EN
  logic [15:0]       stat_retry, stat_timeout;
`endif

  modport slave (
    input  fs_send, send_btype, send_dlen, send_ram_init, fd_read, fd_tx, fs_rx, rx_btype,
`ifdef COM_ARQ_STAT_EN
    output stat_retry, stat_timeout,
`endif
    output fd_send, send_result, send_tries, fs_read, read_btype,
    output fs_tx, tx_btype, tx_ram_init, tx_ram_rlen, fd_rx
  );

  modport master (
    output fs_send, send_btype, send_dlen, send_ram_init, fd_read, fd_tx, fs_rx, rx_btype,
`ifdef COM_ARQ_STAT_EN
    input  stat_retry, stat_timeout,
`endif
    input  fd_send, send_result, send_tries, fs_read, read_btype,
    input  fs_tx, tx_btype, tx_ram_init, tx_ram_rlen, fd_rx
  );
endinterface

// File: rtl/com_arq_timer.sv
// Answer-wait timer: load clears, enable counts, expire flags the last cycle of the window.
module com_arq_timer #(
  parameter int TIMEOUT = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/com_arq.sv
// Link-level send/receive sequencer with NAK/timeout retransmission and ACK/NAK answering.
// Optional statistics counters: define COM_ARQ_STAT_EN.
module com_arq
  import com_pkg::*;
#(
  parameter int TIMEOUT = 128,
  parameter int MAX_TRY = 16,
  parameter int ADDR_W  = 12
) (
  input logic      clk,
  input logic      rst,
  com_arq_if.slave bus
);
  state_e            state_q, goto_q;
  send_result_e      result_q;
  logic [7:0]        tries_q, nak_q;
  logic              deliver_q;
  logic [3:0]        tx_btype_q, read_btype_q;
  logic [ADDR_W-1:0] tx_init_q, tx_rlen_q;
  logic              expire, can_retry;

  com_arq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == SEND_DATA),
    .en_i    (state_q == RANS_WAIT),
    .expire_o(expire)
  );

  assign can_retry = tries_q < 8'(MAX_TRY);

`ifdef COM_ARQ_STAT_EN
  logic [15:0] stat_retry_q, stat_timeout_q;
  assign bus.stat_retry   = stat_retry_q;
  assign bus.stat_timeout = stat_timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MAIN_IDLE;
      goto_q       <= MAIN_IDLE;
      result_q     <= RES_NONE;
      tries_q      <= '0;
      nak_q        <= '0;
      deliver_q    <= 1'b0;
      tx_btype_q   <= BAG_INIT;
      read_btype_q <= BAG_INIT;
      tx_init_q    <= '0;
      tx_rlen_q    <= '0;
`ifdef COM_ARQ_STAT_EN
      stat_retry_q   <= '0;
      stat_timeout_q <= '0;
`endif
    end else begin
      case (state_q)
        MAIN_IDLE: state_q <= MAIN_WAIT;
        MAIN_WAIT: begin
          if (bus.fs_send)    state_q <= SEND_PREP;
          else if (bus.fs_rx) state_q <= READ_PREP;
        end
        SEND_PREP: begin
          tx_btype_q <= bus.send_btype;
          tx_init_q  <= bus.send_ram_init;
          tx_rlen_q  <= bus.send_dlen;
          tries_q    <= 8'd1;
          result_q   <= RES_NONE;
          state_q    <= SEND_DATA;
        end
        SEND_DATA: if (bus.fd_tx) state_q <= RANS_WAIT;
        RANS_WAIT: begin
          // the timeout deliberately beats an answer arriving in the same cycle
          if (expire) begin
`ifdef COM_ARQ_STAT_EN
            stat_timeout_q <= sat_inc16(stat_timeout_q);
            if (can_retry) stat_retry_q <= sat_inc16(stat_retry_q);
`endif
            if (can_retry) begin
              tries_q <= tries_q + 8'd1;
              state_q <= SEND_DATA;
            end else begin
              result_q <= RES_TMO;
              state_q  <= SEND_DONE;
            end
          end else if (bus.fs_rx) begin
            state_q <= RANS_TAKE;
          end
        end
        RANS_TAKE: begin
          if (bus.rx_btype == BAG_ACK) begin
            goto_q   <= SEND_DONE;
            result_q <= RES_ACK;
          end else if (can_retry) begin
            goto_q  <= SEND_DATA;
            tries_q <= tries_q + 8'd1;
`ifdef COM_ARQ_STAT_EN
            stat_retry_q <= sat_inc16(stat_retry_q);
`endif
          end else begin
            goto_q   <= SEND_DONE;
            result_q <= RES_NAK;
          end
          state_q <= RANS_DONE;
        end
        RANS_DONE: if (!bus.fs_rx)   state_q <= goto_q;
        SEND_DONE: if (!bus.fs_send) state_q <= MAIN_WAIT;
        READ_PREP: state_q <= READ_DATA;
        READ_DATA: if (!bus.fs_rx)   state_q <= WANS_PREP;
        WANS_PREP: begin
          // once the NAK budget is spent the error packet is accepted and passed up
          if (bus.rx_btype == BAG_ERROR && nak_q < 8'(MAX_TRY - 1)) begin
            tx_btype_q <= BAG_NAK;
            nak_q      <= nak_q + 8'd1;
            deliver_q  <= 1'b0;
          end else begin
            tx_btype_q   <= BAG_ACK;
            deliver_q    <= 1'b1;
            read_btype_q <= bus.rx_btype;
            nak_q        <= '0;
          end
          tx_rlen_q <= '0;
          state_q   <= WANS_DONE;
        end
        WANS_DONE: if (bus.fd_tx)   state_q <= deliver_q ? READ_DONE : MAIN_WAIT;
        READ_DONE: if (bus.fd_read) state_q <= MAIN_WAIT;
        default:   state_q <= MAIN_IDLE;
      endcase
    end
  end

  assign bus.fd_send     = (state_q == SEND_DONE);
  assign bus.fs_tx       = (state_q == SEND_DATA) || (state_q == WANS_DONE);
  assign bus.fd_rx       = (state_q == READ_DATA) || (state_q == RANS_DONE);
  assign bus.fs_read     = (state_q == READ_DONE);
  assign bus.send_result = result_q;
  assign bus.send_tries  = tries_q;
  assign bus.tx_btype    = tx_btype_q;
  assign bus.tx_ram_init = tx_init_q;
  assign bus.tx_ram_rlen = tx_rlen_q;
  assign bus.read_btype  = read_btype_q;
endmodule

// File: tb/tb_com_arq.sv
// Randomized scoreboard bench for com_arq: bench plays upper layer, framer and peer.
module tb_com_arq;
  import com_pkg::*;

  localparam int TO = 8;
  localparam int MT = 4;
  localparam int AW = 12;
  localparam int A_NONE = 0, A_ACK = 1, A_NAK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  com_arq_if #(.ADDR_W(AW)) bus();
  com_arq #(.TIMEOUT(TO), .MAX_TRY(MT), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int res; int tries; int bt; int dlen; int init;} exp_s;
  exp_s send_q[$];
  int   ans_q[$];
  int   read_q[$];
  int   vectors = 0, miscompares = 0;
  int   plan[MT];
  int   model_nak = 0;
  int   nak_types[11] = '{2, 3, 5, 6, 7, 8, 9, 10, 13, 14, 15};
  int   data_types[10] = '{3, 5, 6, 7, 8, 9, 10, 13, 14, 2};

  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic note_fail(input string n);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected", n);
  endtask

  // Scoreboard monitor: pops an expectation on every rising output event.
  initial begin
    logic ptx, psd, prd;
    int   pulses;
    exp_s e;
    ptx = 0; psd = 0; prd = 0; pulses = 0;
    forever begin
      @(negedge clk);
      if (rst) pulses = 0;
      else begin
        if (bus.fs_tx && !ptx) begin
          if (bus.tx_ram_rlen != 0) pulses++;
          else if (ans_q.size() == 0) note_fail("unexpected_answer_tx");
          else chk("answer_type", int'(bus.tx_btype), ans_q.pop_front());
        end
        if (bus.fd_send && !psd) begin
          if (send_q.size() == 0) note_fail("unexpected_fd_send");
          else begin
            e = send_q.pop_front();
            chk("send_result", int'(bus.send_result), e.res);
            chk("send_tries", int'(bus.send_tries), e.tries);
            chk("tx_pulses", pulses, e.tries);
            chk("tx_btype", int'(bus.tx_btype), e.bt);
            chk("tx_ram_rlen", int'(bus.tx_ram_rlen), e.dlen);
            chk("tx_ram_init", int'(bus.tx_ram_init), e.init);
          end
          pulses = 0;
        end
        if (bus.fs_read && !prd) begin
          if (read_q.size() == 0) note_fail("unexpected_fs_read");
          else chk("read_btype", int'(bus.read_btype), read_q.pop_front());
        end
      end
      ptx = bus.fs_tx; psd = bus.fd_send; prd = bus.fs_read;
    end
  end

  task automatic check_rst(input string tag);
    chk({tag, "_fd_send"}, int'(bus.fd_send), 0);
    chk({tag, "_fs_tx"}, int'(bus.fs_tx), 0);
    chk({tag, "_fd_rx"}, int'(bus.fd_rx), 0);
    chk({tag, "_fs_read"}, int'(bus.fs_read), 0);
    chk({tag, "_result"}, int'(bus.send_result), 0);
    chk({tag, "_tries"}, int'(bus.send_tries), 0);
    chk({tag, "_tx_btype"}, int'(bus.tx_btype), int'(BAG_INIT));
    chk({tag, "_read_btype"}, int'(bus.read_btype), int'(BAG_INIT));
    chk({tag, "_tx_init"}, int'(bus.tx_ram_init), 0);
    chk({tag, "_tx_rlen"}, int'(bus.tx_ram_rlen), 0);
  endtask

  task automatic pulse_fd_tx();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.fd_tx = 1'b1;
    @(negedge clk);
    bus.fd_tx = 1'b0;
  endtask

  task automatic do_send(input logic [3:0] bt, input logic [AW-1:0] dl,
                         input logic [AW-1:0] ini, input bit tie);
    exp_s e;
    int   k, res, n;
    bit   ok;
    res = 0; k = 0;
    while (res == 0) begin
      k++;
      if (plan[k-1] == A_ACK) res = 1;
      else if (k == MT) res = (plan[k-1] == A_NONE) ? 3 : 2;
    end
    e.res = res; e.tries = k; e.bt = int'(bt); e.dlen = int'(dl); e.init = int'(ini);
    send_q.push_back(e);
    @(negedge clk);
    bus.send_btype = bt; bus.send_dlen = dl; bus.send_ram_init = ini; bus.fs_send = 1'b1;
    if (tie) begin bus.fs_rx = 1'b1; bus.rx_btype = BAG_DATA0; end
    @(negedge clk);
    chk("tx_latency_early", int'(bus.fs_tx), 0);
    bus.fs_rx = 1'b0;
    @(negedge clk);
    chk("first_tx_latency", int'(bus.fs_tx), 1);
    if (tie) chk("tie_no_read", int'(bus.fd_rx), 0);
    ok = 1;
    for (int a = 0; a < k; a++) begin
      if (ok) begin
        n = 0;
        while (!bus.fs_tx && n < 50) begin @(negedge clk); n++; end
        if (!bus.fs_tx) begin note_fail("tx_wait"); ok = 0; end
        else begin
          pulse_fd_tx();
          if (plan[a] == A_NONE) begin
            if (a < k - 1) begin
              n = 1;
              while (!bus.fs_tx && n < 50) begin @(negedge clk); n++; end
              chk("timeout_gap", n, TO + 1);
            end
          end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.rx_btype = (plan[a] == A_ACK) ? BAG_ACK : 4'(nak_types[$urandom_range(0, 10)]);
            bus.fs_rx = 1'b1;
            n = 0;
            while (!bus.fd_rx && n < 20) begin @(negedge clk); n++; end
            if (!bus.fd_rx) begin note_fail("answer_taken"); ok = 0; end
            bus.fs_rx = 1'b0;
          end
        end
      end
    end
    n = 0;
    while (!bus.fd_send && n < 50) begin @(negedge clk); n++; end
    chk("fd_send_seen", int'(bus.fd_send), 1);
    @(negedge clk);
    bus.fs_send = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input logic [3:0] t);
    bit dlv;
    int n;
    dlv = !(t == BAG_ERROR && model_nak < MT - 1);
    if (dlv) begin
      ans_q.push_back(int'(BAG_ACK)); read_q.push_back(int'(t)); model_nak = 0;
    end else begin
      ans_q.push_back(int'(BAG_NAK)); model_nak++;
    end
    @(negedge clk);
    bus.rx_btype = t; bus.fs_rx = 1'b1;
    n = 0;
    while (!bus.fd_rx && n < 20) begin @(negedge clk); n++; end
    if (!bus.fd_rx) note_fail("read_taken");
    bus.fs_rx = 1'b0;
    n = 0;
    while (!bus.fs_tx && n < 20) begin @(negedge clk); n++; end
    if (!bus.fs_tx) note_fail("answer_tx_wait");
    else pulse_fd_tx();
    if (dlv) begin
      n = 0;
      while (!bus.fs_read && n < 20) begin @(negedge clk); n++; end
      chk("fs_read_seen", int'(bus.fs_read), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.fd_read = 1'b1;
      @(negedge clk);
      bus.fd_read = 1'b0;
    end else begin
      repeat (2) @(negedge clk);
      chk("nak_no_read", int'(bus.fs_read), 0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int r, n;
    bus.fs_send = 0; bus.send_btype = '0; bus.send_dlen = '0; bus.send_ram_init = '0;
    bus.fd_read = 0; bus.fd_tx = 0; bus.fs_rx = 0; bus.rx_btype = '0;
    repeat (3) @(negedge clk);
    check_rst("rst0");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    plan = '{A_ACK, A_ACK, A_ACK, A_ACK};     do_send(BAG_DATA0, 12'h123, 12'h040, 0);
    plan = '{A_NAK, A_NAK, A_ACK, A_NONE};    do_send(BAG_DATA1, 12'h010, 12'h200, 0);
    plan = '{A_NONE, A_NONE, A_NONE, A_NONE}; do_send(BAG_DIDX, 12'h0FF, 12'h7A0, 0);
    plan = '{A_NAK, A_NAK, A_NAK, A_NAK};     do_send(BAG_DTEMP, 12'hFFF, 12'h001, 0);

    repeat (3) do_read(BAG_ERROR);
    do_read(BAG_DATA1);
    repeat (4) do_read(BAG_ERROR);

    plan = '{A_ACK, A_ACK, A_ACK, A_ACK};     do_send(BAG_STL, 12'h005, 12'h300, 1);

    // abort a transfer while it waits for the peer
    @(negedge clk);
    bus.send_btype = BAG_DATA0; bus.send_dlen = 12'h044; bus.send_ram_init = 12'h123;
    bus.fs_send = 1'b1;
    n = 0;
    while (!bus.fs_tx && n < 10) begin @(negedge clk); n++; end
    if (!bus.fs_tx) note_fail("rst_case_tx_wait");
    bus.fd_tx = 1'b1;
    @(negedge clk);
    bus.fd_tx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; bus.fs_send = 1'b0;
    @(negedge clk);
    check_rst("rst_mid");
    rst = 1'b0;
    model_nak = 0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int a = 0; a < MT; a++) begin
          r = $urandom_range(0, 9);
          plan[a] = (r < 4) ? A_ACK : (r < 7) ? A_NAK : A_NONE;
        end
        do_send(4'(data_types[$urandom_range(0, 9)]), AW'($urandom_range(1, 4095)),
                AW'($urandom_range(0, 4095)), 0);
      end else begin
        if ($urandom_range(0, 9) < 4) do_read(BAG_ERROR);
        else do_read(4'(data_types[$urandom_range(0, 8)]));
      end
    end

    repeat (4) @(negedge clk);
    chk("leftover_expectations", send_q.size() + ans_q.size() + read_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
